// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: DECODE -> READ -> EXEC -> MEM -> WB with per-class
// phase skipping, global stall, memory-wait handshake and a retired-instruction counter.
module multicycle_control #(
    parameter int OPW        = 4,
    parameter int ALU_CYCLES = 1,
    parameter int MUL_CYCLES = 4,
    parameter int CNTW       = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [OPW-1:0]  Opcode,
    input  logic            Stall,
    input  logic            MemReady,
    output logic            Ready,
    output logic            Wen,
    output logic            MemEn,
    output logic            Done,
    output logic [2:0]      Phase,
    output logic [CNTW-1:0] Retired
);

    localparam int MAXC = (MUL_CYCLES > ALU_CYCLES) ? MUL_CYCLES : ALU_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [OPW-1:0]  r_op, w_op_next;
    logic            r_done;
    logic [CNTW-1:0] r_retired;
    logic            w_complete;
    logic            w_is_nop, w_is_mul, w_is_load, w_is_store;

    assign w_is_nop   = (r_op == OPW'(0));
    assign w_is_mul   = (r_op == OPW'(8));
    assign w_is_load  = (r_op == OPW'(9));
    assign w_is_store = (r_op == OPW'(10));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_done    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_done  <= w_complete;
            if (w_complete)
                r_retired <= r_retired + CNTW'(1);
        end
    end

    // Stall freezes every non-IDLE state; illegal encodings recover to IDLE regardless.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_op_next  = r_op;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next    = S_DECODE;
                    w_op_next = Opcode;
                end
            end
            S_DECODE: begin
                if (!Stall) begin
                    if (w_is_nop) begin
                        w_next     = S_IDLE;
                        w_complete = 1'b1;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!Stall) begin
                    w_cnt_next = w_is_mul ? CW'(MUL_CYCLES - 1) : CW'(ALU_CYCLES - 1);
                    w_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!Stall) begin
                    if (r_cnt != '0)
                        w_cnt_next = r_cnt - CW'(1);
                    else if (w_is_load || w_is_store)
                        w_next = S_MEM;
                    else
                        w_next = S_WB;
                end
            end
            S_MEM: begin
                if (!Stall && MemReady) begin
                    if (w_is_store) begin
                        w_next     = S_IDLE;
                        w_complete = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                if (!Stall) begin
                    w_next     = S_IDLE;
                    w_complete = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign Ready   = (r_state == S_IDLE);
    assign Wen     = (r_state == S_WB);
    assign MemEn   = (r_state == S_MEM);
    assign Phase   = r_state;
    assign Done    = r_done;
    assign Retired = r_retired;

endmodule
